top_sequencer: RTL

TOP_SEQUENCER -- requirements
Module: top_sequencer

---
 rtl/top_sequencer_pkg.sv | 42 ++++
 rtl/top_sequencer_sram_mux.sv | 45 ++++
 rtl/top_sequencer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/top_sequencer_pkg.sv
// Shared types for the top-level decode sequencer: FSM state and SRAM owner
// encodings plus small helpers used by the sequencer and its SRAM mux.
package top_sequencer_pkg;

    localparam int ADDR_W  = 18;
    localparam int DATA_W  = 16;
    localparam int WDOG_W  = 24;
    localparam int GUARD_W = 2;

    // Stale done levels are ignored until this many edges after a stage start.
    localparam logic [GUARD_W-1:0] GUARD_LOAD = 2'd2;

    typedef enum logic [2:0] {
        S_TOP_IDLE  = 3'd0,
        S_TOP_UART  = 3'd1,
        S_TOP_M2    = 3'd2,
        S_TOP_M1    = 3'd3,
        S_TOP_DONE  = 3'd4,
        S_TOP_ERROR = 3'd7
    } TOP_state_type;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_UART = 2'd1,
        OWN_M2   = 2'd2,
        OWN_M1   = 2'd3
    } owner_type;

    function automatic owner_type owner_for(input TOP_state_type s);
        case (s)
            S_TOP_UART: owner_for = OWN_UART;
            S_TOP_M2:   owner_for = OWN_M2;
            S_TOP_M1:   owner_for = OWN_M1;
            default:    owner_for = OWN_NONE;
        endcase
    endfunction

    function automatic logic stage_busy(input TOP_state_type s);
        return (s == S_TOP_UART) || (s == S_TOP_M2) || (s == S_TOP_M1);
    endfunction

endpackage

// File: rtl/top_sequencer_sram_mux.sv
// Combinational SRAM port select: passes exactly one requester's bus to the
// shared SRAM port, or an idle bus (no write, zero address/data) when unowned.
module sram_mux
    import top_sequencer_pkg::*;
(
    input  owner_type           owner_i,
    input  logic [ADDR_W-1:0]   uart_addr_i,
    input  logic [DATA_W-1:0]   uart_wdata_i,
    input  logic                uart_we_n_i,
    input  logic [ADDR_W-1:0]   m2_addr_i,
    input  logic [DATA_W-1:0]   m2_wdata_i,
    input  logic                m2_we_n_i,
    input  logic [ADDR_W-1:0]   m1_addr_i,
    input  logic [DATA_W-1:0]   m1_wdata_i,
    input  logic                m1_we_n_i,
    output logic [ADDR_W-1:0]   sram_addr_o,
    output logic [DATA_W-1:0]   sram_wdata_o,
    output logic                sram_we_n_o
);

    always_comb begin
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        sram_we_n_o  = 1'b1;
        case (owner_i)
            OWN_UART: begin
                sram_addr_o  = uart_addr_i;
                sram_wdata_o = uart_wdata_i;
                sram_we_n_o  = uart_we_n_i;
            end
            OWN_M2: begin
                sram_addr_o  = m2_addr_i;
                sram_wdata_o = m2_wdata_i;
                sram_we_n_o  = m2_we_n_i;
            end
            OWN_M1: begin
                sram_addr_o  = m1_addr_i;
                sram_wdata_o = m1_wdata_i;
                sram_we_n_o  = m1_we_n_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/top_sequencer.sv
// Top-level decode sequencer: runs UART -> M2 -> M1 and arbitrates the SRAM.
// Optional per-stage watchdog is built when SEQ_TIMEOUT_EN is defined.
module top_sequencer
    import top_sequencer_pkg::*;
#(
    parameter logic [WDOG_W-1:0] TIMEOUT_CYCLES = 24'd10_000_000
) (
    input  logic                CLOCK_50_I,
    input  logic                Resetn,
    input  logic                start_i,

    output logic                UART_start,
    output logic                M2_start,
    output logic                M1_start,
    input  logic                UART_done,
    input  logic                M2_done,
    input  logic                M1_done,

    input  logic [ADDR_W-1:0]   UART_SRAM_address,
    input  logic [DATA_W-1:0]   UART_SRAM_write_data,
    input  logic                UART_SRAM_we_n,
    input  logic [ADDR_W-1:0]   M2_SRAM_address,
    input  logic [DATA_W-1:0]   M2_SRAM_write_data,
    input  logic                M2_SRAM_we_n,
    input  logic [ADDR_W-1:0]   M1_SRAM_address,
    input  logic [DATA_W-1:0]   M1_SRAM_write_data,
    input  logic                M1_SRAM_we_n,

    output logic [ADDR_W-1:0]   SRAM_address,
    output logic [DATA_W-1:0]   SRAM_write_data,
    output logic                SRAM_we_n,

    output logic                busy_o,
    output logic [2:0]          stage_o,
    output logic                error_o
);

    TOP_state_type        state_q, state_d;
    owner_type            owner_q, owner_d;
    owner_type            owner_grant;
    logic                 uart_start_q, uart_start_d;
    logic                 m2_start_q, m2_start_d;
    logic                 m1_start_q, m1_start_d;
    logic [GUARD_W-1:0]   guard_q, guard_d;
    logic                 busy;
    logic                 done_cur;
    logic                 done_qual;
    logic                 timeout_hit;

    assign busy = stage_busy(state_q);

    always_comb begin
        case (state_q)
            S_TOP_UART: done_cur = UART_done;
            S_TOP_M2:   done_cur = M2_done;
            S_TOP_M1:   done_cur = M1_done;
            default:    done_cur = 1'b0;
        endcase
    end

    // A done level is trusted only once the guard has drained after the start.
    assign done_qual = (guard_q == '0) && done_cur;

    always_comb begin
        state_d      = state_q;
        uart_start_d = 1'b0;
        m2_start_d   = 1'b0;
        m1_start_d   = 1'b0;
        guard_d      = (guard_q != '0) ? guard_q - GUARD_W'(1) : '0;
        case (state_q)
            S_TOP_IDLE, S_TOP_DONE, S_TOP_ERROR: begin
                if (start_i) begin
                    state_d      = S_TOP_UART;
                    uart_start_d = 1'b1;
                    guard_d      = GUARD_LOAD;
                end
            end
            S_TOP_UART: begin
                if (done_qual) begin
                    state_d    = S_TOP_M2;
                    m2_start_d = 1'b1;
                    guard_d    = GUARD_LOAD;
                end else if (timeout_hit) begin
                    state_d = S_TOP_ERROR;
                end
            end
            S_TOP_M2: begin
                if (done_qual) begin
                    state_d    = S_TOP_M1;
                    m1_start_d = 1'b1;
                    guard_d    = GUARD_LOAD;
                end else if (timeout_hit) begin
                    state_d = S_TOP_ERROR;
                end
            end
            S_TOP_M1: begin
                if (done_qual) begin
                    state_d = S_TOP_DONE;
                    guard_d = '0;
                end else if (timeout_hit) begin
                    state_d = S_TOP_ERROR;
                end
            end
            default: state_d = S_TOP_IDLE;
        endcase
    end

    // Owner follows the next state so the new owner's bus is live in its start cycle.
    always_comb begin
        owner_d = owner_for(state_d);
    end

    always_ff @(posedge CLOCK_50_I) begin
        if (!Resetn) begin
            state_q      <= S_TOP_IDLE;
            owner_q      <= OWN_NONE;
            uart_start_q <= 1'b0;
            m2_start_q   <= 1'b0;
            m1_start_q   <= 1'b0;
            guard_q      <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            uart_start_q <= uart_start_d;
            m2_start_q   <= m2_start_d;
            m1_start_q   <= m1_start_d;
            guard_q      <= guard_d;
        end
    end

`ifdef SEQ_TIMEOUT_EN
    logic [WDOG_W-1:0] wdog_q, wdog_d;

    always_comb begin
        if (uart_start_d || m2_start_d || m1_start_d) begin
            wdog_d = '0;
        end else if (busy) begin
            wdog_d = wdog_q + WDOG_W'(1);
        end else begin
            wdog_d = '0;
        end
    end

    assign timeout_hit = busy && (wdog_q >= (TIMEOUT_CYCLES - WDOG_W'(1)));

    always_ff @(posedge CLOCK_50_I) begin
        if (!Resetn) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end

    assign error_o = (state_q == S_TOP_ERROR);
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout_hit        = 1'b0;
    assign error_o            = 1'b0;
`endif

    // Reset forces the bus idle immediately, before the first reset edge lands.
    always_comb begin
        owner_grant = OWN_NONE;
        if (Resetn) begin
            owner_grant = owner_q;
        end
    end

    sram_mux u_sram_mux (
        .owner_i      (owner_grant),
        .uart_addr_i  (UART_SRAM_address),
        .uart_wdata_i (UART_SRAM_write_data),
        .uart_we_n_i  (UART_SRAM_we_n),
        .m2_addr_i    (M2_SRAM_address),
        .m2_wdata_i   (M2_SRAM_write_data),
        .m2_we_n_i    (M2_SRAM_we_n),
        .m1_addr_i    (M1_SRAM_address),
        .m1_wdata_i   (M1_SRAM_write_data),
        .m1_we_n_i    (M1_SRAM_we_n),
        .sram_addr_o  (SRAM_address),
        .sram_wdata_o (SRAM_write_data),
        .sram_we_n_o  (SRAM_we_n)
    );

    assign UART_start = uart_start_q;
    assign M2_start   = m2_start_q;
    assign M1_start   = m1_start_q;
    assign busy_o     = busy;
    assign stage_o    = state_q;

endmodule
